// File: rtl/dmem_access_ctl.sv
// ---------------------------------------------------------------------------
// dmem_access_ctl
//
// Memory-access stage of the sail core, sitting right after the ALU. It
// turns an EX-stage load/store into transactions on a word-wide req/ack
// data-memory port that has no byte enables. Sub-word stores are done as a
// read-modify-write (RD then WR). Load results are sign- or zero-extended.
// The upstream pipeline is stalled while a transaction is outstanding.
//
// Parameters
//   TIMEOUT_CYCLES : cycles to wait for mem_ack before aborting with bus_err
//                    (0 disables the timeout)
//   CNT_W          : width of the timeout counter, must hold TIMEOUT_CYCLES
//
// Ports
//   clk, reset          : core clock (rising edge), async active-high reset
//   ex_valid            : EX stage holds a valid instruction
//   ex_is_load/_store   : access type (both set -> treated as a load)
//   ex_funct3           : RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   ex_addr, ex_wdata   : byte address and store data (rs2)
//   stall               : hold upstream pipeline
//   ld_data, ld_valid   : extended load result and its one-cycle strobe
//   misalign_err        : one-cycle pulse, misaligned access rejected
//   bus_err             : one-cycle pulse, memory timeout
//   mem_req, mem_we     : memory request / write select
//   mem_addr, mem_wdata : word address and write word
//   mem_ack, mem_rdata  : handshake completion and read word
// ---------------------------------------------------------------------------
module dmem_access_ctl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        ld_valid,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    // The counter is compared against the last waiting cycle so that mem_req
    // stays high for exactly TIMEOUT_CYCLES cycles before the abort.
    localparam bit              TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TMO_LAST =
        TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              is_load_q, is_load_d;
    logic              err_bus_q, err_bus_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       ld_data_q, ld_data_d;

    logic              accept;
    logic              misaligned;
    logic              word_store;
    logic              timeout_hit;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_ext;
    logic [31:0]       merged;

    // -----------------------------------------------------------------------
    // Request decode on the live EX inputs (only meaningful in IDLE).
    // -----------------------------------------------------------------------
    assign accept     = ex_valid & (ex_is_load | ex_is_store);
    assign word_store = ~ex_is_load & (ex_funct3 == 3'b010);

    // Undefined funct3 encodings are rejected the same way as misaligned ones.
    always_comb begin
        misaligned = 1'b0;
        case (ex_funct3)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = ex_addr[0];
            3'b010:         misaligned = (ex_addr[1:0] != 2'b00);
            default:        misaligned = 1'b1;
        endcase
    end

    assign timeout_hit = TMO_EN && (cnt_q == TMO_LAST);

    // -----------------------------------------------------------------------
    // Little-endian lane selection and load extension from the read word.
    // -----------------------------------------------------------------------
    always_comb begin
        rd_byte = mem_rdata[7:0];
        case (addr_q[1:0])
            2'd0: rd_byte = mem_rdata[7:0];
            2'd1: rd_byte = mem_rdata[15:8];
            2'd2: rd_byte = mem_rdata[23:16];
            2'd3: rd_byte = mem_rdata[31:24];
            default: rd_byte = mem_rdata[7:0];
        endcase
    end

    assign rd_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_ext = mem_rdata;
        case (funct3_q)
            3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_ext = {24'd0, rd_byte};
            3'b101:  load_ext = {16'd0, rd_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // Read-modify-write merge: the store byte/half replaces its lane in the
    // word just read, everything else is written back unchanged.
    always_comb begin
        merged = mem_rdata;
        if (funct3_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged = mem_rdata;
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic. DONE and ERR always fall back to IDLE so the
    // stale EX operation still on the inputs is not accepted a second time.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        state_d = ERR;
                    end else if (word_store) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (mem_ack) begin
                    state_d = is_load_q ? DONE : WR;
                end else if (timeout_hit) begin
                    state_d = ERR;
                end
            end
            WR: begin
                if (mem_ack) begin
                    state_d = DONE;
                end else if (timeout_hit) begin
                    state_d = ERR;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs decoded from the registered state. mem_req follows the
    // state register, so an async reset drops it immediately.
    // -----------------------------------------------------------------------
    always_comb begin
        stall        = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        ld_valid     = 1'b0;
        misalign_err = 1'b0;
        bus_err      = 1'b0;
        case (state_q)
            IDLE: stall = accept;
            RD: begin
                stall   = 1'b1;
                mem_req = 1'b1;
            end
            WR: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                mem_we  = 1'b1;
            end
            DONE: ld_valid = is_load_q;
            ERR: begin
                misalign_err = ~err_bus_q;
                bus_err      = err_bus_q;
            end
            default: stall = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath next-state: capture on accept, then only the FSM's own
    // transaction updates these registers, which keeps mem_addr/mem_wdata
    // stable for the whole time mem_req is high.
    // -----------------------------------------------------------------------
    always_comb begin
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        is_load_d   = is_load_q;
        err_bus_d   = err_bus_q;
        cnt_d       = cnt_q;
        mem_wdata_d = mem_wdata_q;
        ld_data_d   = ld_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d    = ex_addr;
                    wdata_d   = ex_wdata[15:0];
                    funct3_d  = ex_funct3;
                    is_load_d = ex_is_load;
                    err_bus_d = 1'b0;
                    cnt_d     = '0;
                    if (!ex_is_load) begin
                        mem_wdata_d = ex_wdata;
                    end
                end
            end
            RD: begin
                if (mem_ack) begin
                    cnt_d = '0;
                    if (is_load_q) begin
                        ld_data_d = load_ext;
                    end else begin
                        mem_wdata_d = merged;
                    end
                end else if (timeout_hit) begin
                    err_bus_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WR: begin
                if (!mem_ack) begin
                    if (timeout_hit) begin
                        err_bus_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            is_load_q   <= 1'b0;
            err_bus_q   <= 1'b0;
            cnt_q       <= '0;
            mem_wdata_q <= '0;
            ld_data_q   <= '0;
        end else begin
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            is_load_q   <= is_load_d;
            err_bus_q   <= err_bus_d;
            cnt_q       <= cnt_d;
            mem_wdata_q <= mem_wdata_d;
            ld_data_q   <= ld_data_d;
        end
    end

    assign mem_addr  = addr_q[31:2];
    assign mem_wdata = mem_wdata_q;
    assign ld_data   = ld_data_q;

endmodule

// File: tb/tb_dmem_access_ctl.sv
// ---------------------------------------------------------------------------
// tb_dmem_access_ctl
//
// Self-checking bench for dmem_access_ctl. A pipeline-like driver presents
// EX operations and advances only on a clock edge where stall was low. A
// reference model computes each operation's outcome from byte-lane
// arithmetic on its own copy of memory and queues the expected response; a
// monitor pops and compares whenever the DUT shows a result (ld_valid, an
// error pulse or an acknowledged memory write). A memory responder answers
// requests with driver-chosen latencies, or never, to provoke timeouts.
// ---------------------------------------------------------------------------
module tb_dmem_access_ctl;

    localparam int TMO   = 4;
    localparam int K_LD  = 1;
    localparam int K_WR  = 2;
    localparam int K_MIS = 3;
    localparam int K_BUS = 4;

    typedef struct {
        int          kind;
        logic [31:0] data;
        logic [29:0] waddr;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        misalign_err;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    exp_t        expQ[$];
    logic [31:0] mem    [16];
    logic [31:0] refMem [16];
    logic [31:0] lastLd;
    logic [29:0] curWordAddr;
    int          writeCount;

    bit          rspNoAck;
    int          rspDelay0;
    int          rspDelay1;
    int          rspPhase;
    bit          phaseActive;
    int          waitCnt;
    int          delayCur;
    bit          recReq;
    bit          recWe;
    logic [3:0]  recIdx;
    logic [31:0] recData;

    dmem_access_ctl #(
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ex_valid    (ex_valid),
        .ex_is_load  (ex_is_load),
        .ex_is_store (ex_is_store),
        .ex_funct3   (ex_funct3),
        .ex_addr     (ex_addr),
        .ex_wdata    (ex_wdata),
        .stall       (stall),
        .ld_data     (ld_data),
        .ld_valid    (ld_valid),
        .misalign_err(misalign_err),
        .bus_err     (bus_err),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Reference model: outcome of one EX operation from the memory rules.
    function automatic void modelOp(input bit v, input bit ld, input bit st,
                                    input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] wd, input bit noAck,
                                    input int d0, input int d1,
                                    output int expStall);
        int          size;
        bit          sgn;
        int          off;
        int          idx;
        logic [31:0] mask;
        logic [31:0] word;
        logic [31:0] val;
        exp_t        e;
        expStall = 0;
        if (!(v && (ld || st))) return;
        sgn = 1'b0;
        case (f3)
            3'b000: begin size = 1; sgn = 1'b1; end
            3'b001: begin size = 2; sgn = 1'b1; end
            3'b010: size = 4;
            3'b100: size = 1;
            3'b101: size = 2;
            default: size = 0;
        endcase
        e.data  = '0;
        e.waddr = '0;
        if (size == 0 || (a % size) != 0) begin
            e.kind = K_MIS;
            expQ.push_back(e);
            expStall = 1;
            return;
        end
        if (noAck) begin
            e.kind = K_BUS;
            expQ.push_back(e);
            expStall = 1 + TMO;
            return;
        end
        idx  = int'(a[5:2]);
        off  = int'(a % 4);
        word = refMem[idx];
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        if (ld) begin
            val = (word >> (8 * off)) & mask;
            if (sgn && size < 4 && val[8 * size - 1]) val = val | ~mask;
            e.kind = K_LD;
            e.data = val;
            lastLd = val;
            expStall = 2 + d0;
        end else begin
            if (size == 4) val = wd;
            else val = (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
            refMem[idx] = val;
            e.kind  = K_WR;
            e.data  = val;
            e.waddr = a[31:2];
            expStall = (size == 4) ? (2 + d0) : (3 + d0 + d1);
        end
        expQ.push_back(e);
    endfunction

    task automatic scoreEvent(input int kind, input logic [31:0] data,
                              input logic [29:0] waddr);
        exp_t e;
        if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_event: got kind %0d data 0x%08h, expected none at %0t",
                     kind, data, $time);
        end else begin
            e = expQ.pop_front();
            checkOutput("event_kind", kind, e.kind);
            if (e.kind == K_LD || e.kind == K_WR) checkOutput("event_data", data, e.data);
            if (e.kind == K_WR) checkOutput("write_addr", {2'b00, waddr}, {2'b00, e.waddr});
        end
    endtask

    // Memory responder: acks each request phase after the chosen delay.
    always @(negedge clk) begin
        recReq  = mem_req;
        recWe   = mem_we;
        recIdx  = mem_addr[3:0];
        recData = mem_wdata;
    end

    initial begin
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        phaseActive = 1'b0;
        waitCnt     = 0;
        delayCur    = 0;
        forever begin
            @(posedge clk);
            if (mem_ack && recReq) begin
                if (recWe) mem[recIdx] = recData;
                phaseActive = 1'b0;
            end
            #2;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (mem_req) begin
                if (!phaseActive) begin
                    phaseActive = 1'b1;
                    waitCnt     = 0;
                    delayCur    = rspNoAck ? 1000 : ((rspPhase == 0) ? rspDelay0 : rspDelay1);
                    rspPhase++;
                end
                if (waitCnt == delayCur) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr[3:0]];
                end
                waitCnt++;
            end else begin
                phaseActive = 1'b0;
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_req && mem_ack) begin
                checkOutput("mem_addr", {2'b00, mem_addr}, {2'b00, curWordAddr});
                if (mem_we) begin
                    writeCount++;
                    scoreEvent(K_WR, mem_wdata, mem_addr);
                end
            end
            if (ld_valid)     scoreEvent(K_LD, ld_data, '0);
            if (misalign_err) scoreEvent(K_MIS, '0, '0);
            if (bus_err)      scoreEvent(K_BUS, '0, '0);
        end
    end

    // Present one EX operation and hold it until an edge with stall low.
    task automatic applyStimulus(input bit v, input bit ld, input bit st,
                                 input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input bit noAck,
                                 input int d0, input int d1);
        int expStall;
        int n;
        bit s;
        bit done;
        @(negedge clk);
        rspNoAck    = noAck;
        rspDelay0   = d0;
        rspDelay1   = d1;
        rspPhase    = 0;
        curWordAddr = a[31:2];
        modelOp(v, ld, st, f3, a, wd, noAck, d0, d1, expStall);
        ex_valid    = v;
        ex_is_load  = ld;
        ex_is_store = st;
        ex_funct3   = f3;
        ex_addr     = a;
        ex_wdata    = wd;
        n    = 0;
        done = 1'b0;
        for (int g = 0; g < 60; g++) begin
            #1 s = stall;
            @(posedge clk);
            if (!s) begin
                done = 1'b1;
                break;
            end
            n++;
            @(negedge clk);
        end
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL op_hang: stall still high after 60 cycles, expected %0d", expStall);
        end else begin
            checkOutput("stall_cycles", n, expStall);
        end
        #1 checkOutput("ld_hold", ld_data, lastLd);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        bit          v;
        bit          ld;
        bit          st;
        int          r;
        int          wc;

        reset       = 1'b1;
        ex_valid    = 1'b0;
        ex_is_load  = 1'b0;
        ex_is_store = 1'b0;
        ex_funct3   = '0;
        ex_addr     = '0;
        ex_wdata    = '0;
        rspNoAck    = 1'b0;
        rspDelay0   = 0;
        rspDelay1   = 0;
        rspPhase    = 0;
        curWordAddr = '0;
        writeCount  = 0;
        lastLd      = '0;
        for (int i = 0; i < 16; i++) begin
            mem[i]    = $urandom;
            refMem[i] = mem[i];
        end
        mem[0] = 32'h1122_3344; refMem[0] = 32'h1122_3344;
        mem[1] = 32'hDEAD_BEEF; refMem[1] = 32'hDEAD_BEEF;
        mem[2] = 32'h80AB_CDEF; refMem[2] = 32'h80AB_CDEF;

        #12;
        checkOutput("rst_stall",     stall, 0);
        checkOutput("rst_mem_req",   mem_req, 0);
        checkOutput("rst_mem_we",    mem_we, 0);
        checkOutput("rst_ld_data",   ld_data, 0);
        checkOutput("rst_ld_valid",  ld_valid, 0);
        checkOutput("rst_misalign",  misalign_err, 0);
        checkOutput("rst_bus_err",   bus_err, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        @(negedge clk);
        reset = 1'b0;

        // Directed cases from the test plan.
        applyStimulus(1, 1, 0, 3'b010, 32'h0000_1004, 32'h0, 0, 2, 0);
        checkOutput("lw_1004", ld_data, 32'hDEAD_BEEF);
        applyStimulus(1, 1, 0, 3'b000, 32'h0000_100B, 32'h0, 0, 0, 0);
        checkOutput("lb_sign", ld_data, 32'hFFFF_FF80);
        applyStimulus(1, 1, 0, 3'b100, 32'h0000_100B, 32'h0, 0, 1, 0);
        checkOutput("lbu_zero", ld_data, 32'h0000_0080);
        applyStimulus(1, 1, 0, 3'b101, 32'h0000_100A, 32'h0, 0, 0, 0);
        checkOutput("lhu_upper", ld_data, 32'h0000_80AB);
        wc = writeCount;
        applyStimulus(1, 0, 1, 3'b000, 32'h0000_1001, 32'h0000_0055, 0, 1, 1);
        checkOutput("sb_one_write", writeCount - wc, 1);
        checkOutput("sb_merged", mem[0], 32'h1122_5544);
        applyStimulus(1, 1, 0, 3'b001, 32'h0000_0001, 32'h0, 0, 0, 0);
        applyStimulus(1, 1, 0, 3'b010, 32'h0000_1004, 32'h0, 1, 0, 0);
        applyStimulus(1, 1, 0, 3'b010, 32'h0000_1004, 32'h0, 0, 0, 0);
        checkOutput("lw_after_tmo", ld_data, 32'hDEAD_BEEF);

        // Reset in the middle of a read.
        @(negedge clk);
        rspNoAck    = 1'b1;
        rspPhase    = 0;
        curWordAddr = 30'h402;
        ex_valid    = 1'b1;
        ex_is_load  = 1'b1;
        ex_is_store = 1'b0;
        ex_funct3   = 3'b010;
        ex_addr     = 32'h0000_1008;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rd_req_before_rst", mem_req, 1);
        #2 reset = 1'b1;
        #1 checkOutput("rst_drops_req", mem_req, 0);
        ex_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1 checkOutput("stall_after_rst", stall, 0);
        checkOutput("ld_data_after_rst", ld_data, 0);
        lastLd = '0;

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 9) != 0);
            r = $urandom_range(0, 9);
            ld = (r <= 4) || (r == 8);
            st = (r >= 5) && (r <= 8);
            case ($urandom_range(0, 6))
                0: f3 = 3'b000;
                1: f3 = 3'b001;
                2: f3 = 3'b010;
                3: f3 = 3'b100;
                4: f3 = 3'b101;
                default: f3 = 3'($urandom_range(0, 7));
            endcase
            a = 32'h0000_1000 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                else if (f3 == 3'b010) a[1:0] = 2'b00;
            end
            applyStimulus(v, ld, st, f3, a, $urandom, ($urandom_range(0, 24) == 0),
                          $urandom_range(0, 2), $urandom_range(0, 2));
        end

        @(negedge clk);
        ex_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("queue_drained", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctl.md
Name: dmem_access_ctl

Overview:
- Memory-access stage directly downstream of the ALU in the sail core.
- Takes the ALU result as a byte address, together with the rs2 store data and funct3.
- Drives a word-wide, req/ack data-memory port that has no byte enables. Sub-word stores are done as read-modify-write.
- Returns sign- or zero-extended load data, and stalls the pipeline while a transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for mem_ack before aborting with bus_err; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  asynchronous, active-high reset
- ex_valid  input  1  EX stage holds a valid instruction
- ex_is_load  input  1  instruction is a load
- ex_is_store  input  1  instruction is a store
- ex_funct3  input  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- ex_addr  input  32  byte address (ALUOut)
- ex_wdata  input  32  store data (rs2)
- stall  output  1  hold upstream pipeline
- ld_data  output  32  extended load result
- ld_valid  output  1  one-cycle pulse, ld_data valid
- misalign_err  output  1  one-cycle pulse, misaligned access rejected
- bus_err  output  1  one-cycle pulse, memory timeout
- mem_req  output  1  memory request
- mem_we  output  1  1 = write
- mem_addr  output  30  word address = captured addr[31:2]
- mem_wdata  output  32  write word
- mem_ack  input  1  request accepted/completed (read data valid same cycle)
- mem_rdata  input  32  read word

Behaviour:
- Reset (async): state IDLE; all registered outputs 0; ld_data 0; timeout counter 0. mem_req drops immediately, including mid-transaction; the transaction is abandoned.
- States: IDLE, RD, WR, DONE, ERR.
- Accept condition (IDLE only): ex_valid & (ex_is_load | ex_is_store). If both flags are set, the access is treated as a load.
- On accept, capture addr, wdata, funct3 and load/store. Later changes on the ex_* inputs are ignored until IDLE is re-entered.
- Misaligned accesses:
  - H/HU with addr[0]=1 is misaligned.
  - W with addr[1:0]≠0 is misaligned.
  - Undefined funct3 values (011, 110, 111) are treated as misaligned.
- IDLE transitions:
  - misaligned → ERR, no memory access.
  - load or sub-word store → RD.
  - word store → WR.
- RD: mem_req=1, mem_we=0.
  - On mem_ack with a load: register the extracted result into ld_data → DONE.
  - On mem_ack with a store: merge the store byte/half into mem_rdata at its lane, register as mem_wdata → WR.
- WR: mem_req=1, mem_we=1, mem_wdata stable → on mem_ack → DONE.
- DONE: ld_valid=1 for loads (0 for stores) → IDLE unconditionally, so the still-present old EX op is not re-accepted.
- ERR: misalign_err=1 or bus_err=1 (one cycle) → IDLE.
- mem_addr and mem_wdata are held constant while mem_req=1. mem_ack is ignored when mem_req=0.
- Timeout: the counter clears on entry to RD/WR and increments each RD/WR cycle without ack. When count reaches TIMEOUT_CYCLES: mem_req drops, state → ERR with bus_err.
- stall is combinational:
  - 1 in IDLE when the accept condition holds;
  - 1 in RD and WR;
  - 0 in DONE and ERR.
- Lanes are little-endian:
  - byte k = addr[1:0] → bits [8k+7:8k];
  - half at addr[1] → bits [16·addr[1]+15 : 16·addr[1]].
- Load extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- ld_data holds its value until the next load completes.
- Minimum latency with same-cycle ack:
  - load or word store: accept → DONE in 2 cycles;
  - sub-word store: 3 cycles.

Test Plan:
- LW at 0x0000_1004, mem_ack 2 cycles after req, rdata 0xDEAD_BEEF → mem_addr 0x401; ld_valid pulses with ld_data 0xDEADBEEF; stall high from accept until DONE.
- LB at 0x...03 with rdata 0x80AB_CDEF → ld_data 0xFFFF_FF80; LBU same → 0x0000_0080; LHU at 0x...02 → 0x0000_80AB.
- SB wdata 0x55 at 0x0000_1001, RD returns 0x1122_3344 → exactly one write, mem_wdata 0x1122_5544; ld_valid stays 0.
- LH at 0x0000_0001 → misalign_err one pulse, mem_req never asserted, stall high for one cycle only.
- TIMEOUT_CYCLES=4, LW with no ack → mem_req high 4 cycles, then bus_err pulse, return to IDLE; a following LW completes normally.
- Assert reset during RD → mem_req 0 asynchronously, stall 0 after release, no ld_valid, next access behaves normally.
